// File: rtl/noc_pkt_initiator_if.sv
// Bundles the core-side packet handshakes and the NoC-side flit links of the packet initiator.
// master is the initiator's view; slave is the core/NI environment's view.
interface noc_pkt_initiator_if #(
  parameter int FLIT_W          = 16,
  parameter int TOTAL_FLITS     = 4,
  parameter int MAX_OUTSTANDING = 2
);
  localparam int PKT_W = FLIT_W * TOTAL_FLITS;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PKT_W-1:0]  req_pkt;
  logic              req_valid;
  logic              req_ready;
  logic [FLIT_W-1:0] o_flit;
  logic              enable;
  logic              ready;
  logic [FLIT_W-1:0] i_flit;
  logic              i_flit_valid;
  logic              i_flit_ready;
  logic [PKT_W-1:0]  resp_pkt;
  logic              resp_valid;
  logic              resp_ready;
  logic [OUT_W-1:0]  outstanding;
  logic              protocol_err;

  modport master (
    input  req_pkt, req_valid, ready, i_flit, i_flit_valid, resp_ready,
    output req_ready, o_flit, enable, i_flit_ready, resp_pkt, resp_valid,
    output outstanding, protocol_err
  );

  modport slave (
    output req_pkt, req_valid, ready, i_flit, i_flit_valid, resp_ready,
    input  req_ready, o_flit, enable, i_flit_ready, resp_pkt, resp_valid,
    input  outstanding, protocol_err
  );
endinterface

// File: rtl/noc_pkt_initiator.sv
// Serialises request packets into flits (head one cycle after accept) and reassembles response flits (resp_valid one cycle after tail).
// Low ready stalls the current flit in place; low resp_ready holds the response and blocks further response flits.
module noc_pkt_initiator #(
  parameter int FLIT_W          = 16,
  parameter int TOTAL_FLITS     = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                resetn,
  noc_pkt_initiator_if.master bus
);
  localparam int CNT_W = $clog2(TOTAL_FLITS);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(TOTAL_FLITS - 1);
  localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);

  typedef logic [TOTAL_FLITS-1:0][FLIT_W-1:0] pkt_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  pkt_t              tx_buf_q, tx_buf_d;
  pkt_t              rx_buf_q, rx_buf_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic              protocol_err_q, protocol_err_d;

  logic              req_rdy;
  logic              tx_vld;
  logic [FLIT_W-1:0] tx_dat;
  logic              tx_tail_xfer;
  logic              rx_rdy;
  logic              rx_flit_xfer;
  logic              resp_vld;
  logic              resp_xfer;

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_buf_d     = tx_buf_q;
    req_rdy      = 1'b0;
    tx_vld       = 1'b0;
    tx_dat       = '0;
    tx_tail_xfer = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        // Gated by resetn so req_ready reads 0 while reset is held.
        req_rdy = resetn && (outstanding_q < MAX_OUT);
        if (bus.req_valid && req_rdy) begin
          tx_buf_d   = pkt_t'(bus.req_pkt);
          tx_cnt_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_vld = 1'b1;
        tx_dat = tx_buf_q[tx_cnt_q];
        if (bus.ready) begin
          if (tx_cnt_q == LAST_FLIT) begin
            tx_state_d   = TX_IDLE;
            tx_tail_xfer = 1'b1;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_buf_d     = rx_buf_q;
    rx_rdy       = 1'b0;
    rx_flit_xfer = 1'b0;
    resp_vld     = 1'b0;
    resp_xfer    = 1'b0;
    unique case (rx_state_q)
      RX_COLLECT: begin
        rx_rdy       = resetn;
        rx_flit_xfer = bus.i_flit_valid && rx_rdy;
        if (rx_flit_xfer) begin
          rx_buf_d[rx_cnt_q] = bus.i_flit;
          if (rx_cnt_q == LAST_FLIT) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_HOLD;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RX_HOLD: begin
        resp_vld  = 1'b1;
        resp_xfer = bus.resp_ready;
        if (resp_xfer) begin
          rx_state_d = RX_COLLECT;
        end
      end
      default: rx_state_d = RX_COLLECT;
    endcase
  end

  // A tail and a response handshake in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (tx_tail_xfer && !resp_xfer) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (resp_xfer && !tx_tail_xfer && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end
    protocol_err_d = protocol_err_q || (rx_flit_xfer && (outstanding_q == '0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_q     <= TX_IDLE;
      rx_state_q     <= RX_COLLECT;
      tx_cnt_q       <= '0;
      rx_cnt_q       <= '0;
      tx_buf_q       <= '0;
      rx_buf_q       <= '0;
      outstanding_q  <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      tx_state_q     <= tx_state_d;
      rx_state_q     <= rx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      rx_cnt_q       <= rx_cnt_d;
      tx_buf_q       <= tx_buf_d;
      rx_buf_q       <= rx_buf_d;
      outstanding_q  <= outstanding_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign bus.req_ready    = req_rdy;
  assign bus.enable       = tx_vld;
  assign bus.o_flit       = tx_dat;
  assign bus.i_flit_ready = rx_rdy;
  assign bus.resp_valid   = resp_vld;
  assign bus.resp_pkt     = resp_vld ? rx_buf_q : '0;
  assign bus.outstanding  = outstanding_q;
  assign bus.protocol_err = protocol_err_q;
endmodule
